// File: rtl/conv_vect_sched.sv
// Input scheduler for the serial 1x1 conv stage: replays each input value once per output
// channel, adds sop/eop/sof/eof framing, and inserts an idle gap after every pixel.
module conv_vect_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_CH      = 8,
  parameter int unsigned OUT_CH     = 3,
  parameter int unsigned STRING_LEN = 224,
  parameter int unsigned STRING_NUM = 224,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_sof_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned REP_W = (OUT_CH > 1)     ? $clog2(OUT_CH)     : 1;
  localparam int unsigned CH_W  = (IN_CH > 1)      ? $clog2(IN_CH)      : 1;
  localparam int unsigned PIX_W = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam int unsigned ROW_W = (STRING_NUM > 1) ? $clog2(STRING_NUM) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(OUT_CH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IN_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(STRING_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(STRING_NUM - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
  logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic rep_last, ch_last, pix_last, row_last, gap_last;
  logic accept;

  assign rep_last = (rep_cnt_q == REP_LAST);
  assign ch_last  = (ch_cnt_q == CH_LAST);
  assign pix_last = (pix_cnt_q == PIX_LAST);
  assign row_last = (row_cnt_q == ROW_LAST);
  assign gap_last = (gap_cnt_q == GAP_LAST);

  // Ready depends only on registered state, so upstream valid can never loop back into it
  always_comb begin
    in_ready_o = 1'b0;
    if (state_q == IDLE) begin
      in_ready_o = 1'b1;
    end else if (state_q == RUN && rep_last) begin
      in_ready_o = !(ch_last && HAS_GAP);
    end
  end

  assign accept = in_valid_i & in_ready_o;

  // Next state: counters advance on the last repeat whether or not a new word follows
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    row_cnt_d = row_cnt_q;
    gap_cnt_d = gap_cnt_q;
    hold_d    = hold_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (!rep_last) begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end else begin
          if (ch_last) begin
            ch_cnt_d = '0;
            if (pix_last) begin
              pix_cnt_d = '0;
              row_cnt_d = row_last ? '0 : row_cnt_q + ROW_W'(1);
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
          if (ch_last && HAS_GAP) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      hold_d    = in_data_i;
      rep_cnt_d = '0;
      state_d   = RUN;
      // A frame start arriving off the frame origin realigns the position counters
      if (in_sof_i && (ch_cnt_d != '0 || pix_cnt_d != '0 || row_cnt_d != '0)) begin
        ch_cnt_d  = '0;
        pix_cnt_d = '0;
        row_cnt_d = '0;
        err_d     = 1'b1;
      end
    end
  end

  // Output beat for the next cycle, decoded from the next-state counters
  always_comb begin
    valid_d = (state_d == RUN);
    data_d  = valid_d ? hold_d : '0;
    sop_d   = valid_d && ch_cnt_d == '0 && rep_cnt_d == '0 && pix_cnt_d == '0;
    eop_d   = valid_d && ch_cnt_d == CH_LAST && rep_cnt_d == REP_LAST && pix_cnt_d == PIX_LAST;
    sof_d   = sop_d && row_cnt_d == '0;
    eof_d   = eop_d && row_cnt_d == ROW_LAST;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      row_cnt_q <= '0;
      gap_cnt_q <= '0;
      hold_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      row_cnt_q <= row_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_conv_vect_sched.sv
// Scoreboard bench for conv_vect_sched: one instance with a one-cycle gap, one with no gap.
module tb_conv_vect_sched;

  localparam int DW   = 8;
  localparam int IC   = 2;
  localparam int OC   = 3;
  localparam int LEN  = 2;
  localparam int NUM  = 2;
  localparam int LIM  = 200;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          sof;
    logic          eof;
    logic          err;
    logic          last_rep;
    logic          ready;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sof;
  logic          sel0;

  logic          v1_in, v0_in;
  logic          d1_ready, d1_valid, d1_sop, d1_eop, d1_sof, d1_eof, d1_busy, d1_err;
  logic          d0_ready, d0_valid, d0_sop, d0_eop, d0_sof, d0_eof, d0_busy, d0_err;
  logic [DW-1:0] d1_data, d0_data;

  logic          m_ready, m_valid, m_sop, m_eop, m_sof, m_eof, m_busy, m_err;
  logic [DW-1:0] m_data;

  int    checks = 0;
  int    errors = 0;
  int    mch = 0, mpix = 0, mrow = 0;
  int    run_len = 0, max_run = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  assign v1_in = in_valid & ~sel0;
  assign v0_in = in_valid & sel0;

  assign m_ready = sel0 ? d0_ready : d1_ready;
  assign m_valid = sel0 ? d0_valid : d1_valid;
  assign m_data  = sel0 ? d0_data  : d1_data;
  assign m_sop   = sel0 ? d0_sop   : d1_sop;
  assign m_eop   = sel0 ? d0_eop   : d1_eop;
  assign m_sof   = sel0 ? d0_sof   : d1_sof;
  assign m_eof   = sel0 ? d0_eof   : d1_eof;
  assign m_busy  = sel0 ? d0_busy  : d1_busy;
  assign m_err   = sel0 ? d0_err   : d1_err;

  conv_vect_sched #(.DATA_WIDTH(DW), .IN_CH(IC), .OUT_CH(OC), .STRING_LEN(LEN),
                    .STRING_NUM(NUM), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .in_data_i(in_data), .in_valid_i(v1_in), .in_sof_i(in_sof),
    .in_ready_o(d1_ready), .data_o(d1_data), .valid_o(d1_valid), .sop_o(d1_sop),
    .eop_o(d1_eop), .sof_o(d1_sof), .eof_o(d1_eof), .busy_o(d1_busy), .err_o(d1_err));

  conv_vect_sched #(.DATA_WIDTH(DW), .IN_CH(IC), .OUT_CH(OC), .STRING_LEN(LEN),
                    .STRING_NUM(NUM), .GAP_CYCLES(0)) u_dut_nogap (
    .clk(clk), .reset(reset), .in_data_i(in_data), .in_valid_i(v0_in), .in_sof_i(in_sof),
    .in_ready_o(d0_ready), .data_o(d0_data), .valid_o(d0_valid), .sop_o(d0_sop),
    .eop_o(d0_eop), .sof_o(d0_sof), .eof_o(d0_eof), .busy_o(d0_busy), .err_o(d0_err));

  // Pops one expected beat per valid output; idle cycles must carry no flags
  task automatic monitor();
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data=%0d with empty scoreboard", m_data);
        end else begin
          exp_b = sb.pop_front();
          if ({m_data, m_sop, m_eop, m_sof, m_eof, m_err} !==
              {exp_b.data, exp_b.sop, exp_b.eop, exp_b.sof, exp_b.eof, exp_b.err}) begin
            errors++;
            $display("FAIL beat: got data=%0d sop=%b eop=%b sof=%b eof=%b err=%b, want data=%0d sop=%b eop=%b sof=%b eof=%b err=%b",
                     m_data, m_sop, m_eop, m_sof, m_eof, m_err, exp_b.data, exp_b.sop,
                     exp_b.eop, exp_b.sof, exp_b.eof, exp_b.err);
          end
          if (exp_b.last_rep) begin
            checks++;
            if (m_ready !== exp_b.ready) begin
              errors++;
              $display("FAIL ready_last_rep: got %b want %b (data=%0d)", m_ready, exp_b.ready, m_data);
            end
          end
        end
      end else begin
        run_len = 0;
        checks++;
        if ({m_sop, m_eop, m_sof, m_eof, m_err} !== 5'b0) begin
          errors++;
          $display("FAIL idle_flags: got sop/eop/sof/eof/err=%b want 00000",
                   {m_sop, m_eop, m_sof, m_eof, m_err});
        end
      end
    end
  endtask

  // Called at a negedge; offers one word, queues its expected beats, returns after acceptance
  task automatic send(input logic [DW-1:0] d, input logic sof);
    int    n = 0;
    bit    rs;
    beat_t b;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!m_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIM) begin
      errors++;
      $display("FAIL send_timeout: word %0d not accepted after %0d cycles, want acceptance", d, n);
    end else begin
      rs = sof && (mch != 0 || mpix != 0 || mrow != 0);
      if (rs) begin
        mch = 0; mpix = 0; mrow = 0;
      end
      for (int r = 0; r < OC; r++) begin
        b.data     = d;
        b.sop      = (mch == 0 && r == 0 && mpix == 0);
        b.eop      = (mch == IC - 1 && r == OC - 1 && mpix == LEN - 1);
        b.sof      = b.sop && mrow == 0;
        b.eof      = b.eop && mrow == NUM - 1;
        b.err      = rs && r == 0;
        b.last_rep = (r == OC - 1);
        b.ready    = sel0 ? 1'b1 : (mch != IC - 1);
        sb.push_back(b);
      end
      mch++;
      if (mch == IC) begin
        mch = 0;
        mpix++;
        if (mpix == LEN) begin
          mpix = 0;
          mrow++;
          if (mrow == NUM) mrow = 0;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || m_busy) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIM) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, busy=%b, want 0 and 0", sb.size(), m_busy);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    mch = 0; mpix = 0; mrow = 0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_valid, m_data, m_sop, m_eop, m_sof, m_eof, m_busy, m_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%0d flags=%b busy=%b err=%b want all 0",
               m_valid, m_data, {m_sop, m_eop, m_sof, m_eof}, m_busy, m_err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", m_ready);
    end
  endtask

  task automatic test_stream();
    max_run = 0;
    send(8'd0, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'd0 || m_sof !== 1'b1 || m_sop !== 1'b1) begin
      errors++;
      $display("FAIL first_beat_latency: got valid=%b data=%0d sof=%b sop=%b want 1 0 1 1",
               m_valid, m_data, m_sof, m_sop);
    end
    for (int w = 1; w < 8; w++) send(DW'(w), 1'b0);
    drain();
    checks++;
    if (max_run !== IC * OC) begin
      errors++;
      $display("FAIL gap_run_length: got longest run %0d want %0d", max_run, IC * OC);
    end
  endtask

  task automatic test_next_frame();
    send(8'd8, 1'b1);
    checks++;
    if (m_sof !== 1'b1 || m_err !== 1'b0) begin
      errors++;
      $display("FAIL second_frame_sof: got sof=%b err=%b want 1 0", m_sof, m_err);
    end
    for (int w = 9; w < 16; w++) send(DW'(w), 1'b0);
    drain();
  endtask

  task automatic test_starve();
    do_reset();
    send(8'd0, 1'b1);
    send(8'd1, 1'b0);
    drain();
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("FAIL starve_idle: got valid=%b busy=%b want 0 0", m_valid, m_busy);
      end
    end
    send(8'd2, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (m_busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_midpixel_busy: got %b want 0", m_busy);
    end
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    drain();
  endtask

  task automatic test_resync();
    do_reset();
    send(8'd0, 1'b1);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    checks++;
    if (m_err !== 1'b1 || m_sof !== 1'b1 || m_sop !== 1'b1 || m_data !== 8'd3) begin
      errors++;
      $display("FAIL resync_first_beat: got err=%b sof=%b sop=%b data=%0d want 1 1 1 3",
               m_err, m_sof, m_sop, m_data);
    end
    @(negedge clk);
    checks++;
    if (m_err !== 1'b0) begin
      errors++;
      $display("FAIL resync_single_pulse: got err=%b want 0", m_err);
    end
    send(8'd4, 1'b0);
    send(8'd5, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'd0, 1'b1);
    send(8'd1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_data, m_sop, m_eop, m_sof, m_eof, m_busy, m_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b data=%0d flags=%b busy=%b err=%b want all 0",
               m_valid, m_data, {m_sop, m_eop, m_sof, m_eof}, m_busy, m_err);
    end
    sb.delete();
    mch = 0; mpix = 0; mrow = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", m_ready);
    end
    send(8'd0, 1'b1);
    checks++;
    if (m_data !== 8'd0 || m_sof !== 1'b1 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL replay_after_reset: got valid=%b data=%0d sof=%b want 1 0 1", m_valid, m_data, m_sof);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    sel0 = 1'b1;
    do_reset();
    max_run = 0;
    for (int w = 0; w < 8; w++) send(DW'(w), w == 0);
    drain();
    checks++;
    if (max_run !== 8 * OC) begin
      errors++;
      $display("FAIL nogap_run_length: got longest run %0d want %0d", max_run, 8 * OC);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    sel0     = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_next_frame();
    test_starve();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
